// File: rtl/maze_walk_if.sv
// Command/status bundle between the maze controller and the position datapath.
//   master: controller side, drives commands, path_ready, and reads position/status/replay.
//   slave : datapath side, the inverse.
// Commands: ld/init_x/init_y, move/dir, undo, replay.
// Status:   x, y, wrong, at_goal, depth_cnt, full, empty, busy.
// Replay:   path_valid, path_dir, path_ready, replay_done.
interface maze_walk_if #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned DEPTH   = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic               ld;
  logic [COORD_W-1:0] init_x;
  logic [COORD_W-1:0] init_y;
  logic               move;
  logic [1:0]         dir;
  logic               undo;
  logic               replay;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               wrong;
  logic               at_goal;
  logic [CW-1:0]      depth_cnt;
  logic               full;
  logic               empty;
  logic               busy;
  logic               path_valid;
  logic [1:0]         path_dir;
  logic               path_ready;
  logic               replay_done;

  modport master (
    output ld, init_x, init_y, move, dir, undo, replay, path_ready,
    input  x, y, wrong, at_goal, depth_cnt, full, empty, busy, path_valid, path_dir, replay_done
  );

  modport slave (
    input  ld, init_x, init_y, move, dir, undo, replay, path_ready,
    output x, y, wrong, at_goal, depth_cnt, full, empty, busy, path_valid, path_dir, replay_done
  );
endinterface

// File: rtl/maze_walk_datapath.sv
// Maze-walker position datapath with edge-checked moves and a path stack.
// Holds X/Y, applies single-step moves, rejects moves off the grid or into a full
// stack, pops one move per undo (stepping back), and replays the recorded path
// oldest-first over a valid/ready handshake.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - maze_walk_if slave modport (commands in, position/status/replay out)
module maze_walk_datapath #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  maze_walk_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StReplay} state_e;

  state_e             state_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [AW:0]        cnt_q;
  logic [AW-1:0]      idx_q;
  logic               wrong_q, pv_q, rd_q;
  logic [1:0]         pd_q;
  logic [1:0]         stack_q [DEPTH];

  logic               is_full, is_empty;
  logic [AW-1:0]      top_idx, next_idx;
  logic [1:0]         top_dir, step_dir;
  logic [COORD_W-1:0] mv_coord, delta, step_x, step_y;
  logic               mv_ok, push_en, last_beat;

  always_comb begin
    is_full  = (cnt_q == (AW+1)'(DEPTH));
    is_empty = (cnt_q == '0);
    top_idx  = AW'(cnt_q - 1'b1);
    next_idx = idx_q + 1'b1;
    top_dir  = stack_q[top_idx];
    last_beat = (idx_q == top_idx);

    // Out of bounds when the selected coordinate would wrap to/through zero.
    mv_coord = (bus.dir[1] ^ bus.dir[0]) ? x_q : y_q;
    mv_ok    = ((mv_coord + COORD_W'(bus.dir[0])) != '0) && !is_full;

    // Undo applies the bitwise inverse of the popped direction (opposite step).
    step_dir = bus.undo ? ~top_dir : bus.dir;
    delta    = step_dir[0] ? COORD_W'(1) : {COORD_W{1'b1}};
    step_x   = x_q;
    step_y   = y_q;
    if (step_dir[1] ^ step_dir[0]) step_x = x_q + delta;
    else                           step_y = y_q + delta;

    push_en = (state_q == StIdle) && !bus.ld && !bus.undo && bus.move && mv_ok;
  end

  // Stack storage needs no reset: depth_cnt alone marks which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[cnt_q[AW-1:0]] <= bus.dir;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      wrong_q <= 1'b0;
      pv_q    <= 1'b0;
      pd_q    <= 2'b00;
      rd_q    <= 1'b0;
    end else begin
      wrong_q <= 1'b0;
      rd_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.ld) begin
            x_q   <= bus.init_x;
            y_q   <= bus.init_y;
            cnt_q <= '0;
          end else if (bus.undo) begin
            if (is_empty) begin
              wrong_q <= 1'b1;
            end else begin
              x_q   <= step_x;
              y_q   <= step_y;
              cnt_q <= cnt_q - 1'b1;
            end
          end else if (bus.move) begin
            if (!mv_ok) begin
              wrong_q <= 1'b1;
            end else begin
              x_q   <= step_x;
              y_q   <= step_y;
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (bus.replay) begin
            if (is_empty) begin
              rd_q <= 1'b1;
            end else begin
              state_q <= StReplay;
              idx_q   <= '0;
              pv_q    <= 1'b1;
              pd_q    <= stack_q[0];
            end
          end
        end
        StReplay: begin
          if (bus.ld) begin
            // Load aborts the replay without a done pulse.
            state_q <= StIdle;
            pv_q    <= 1'b0;
            x_q     <= bus.init_x;
            y_q     <= bus.init_y;
            cnt_q   <= '0;
          end else if (bus.path_ready) begin
            if (last_beat) begin
              state_q <= StIdle;
              pv_q    <= 1'b0;
              rd_q    <= 1'b1;
            end else begin
              idx_q <= next_idx;
              pd_q  <= stack_q[next_idx];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.wrong       = wrong_q;
  assign bus.at_goal     = (x_q == '1) && (y_q == '1);
  assign bus.depth_cnt   = cnt_q;
  assign bus.full        = is_full;
  assign bus.empty       = is_empty;
  assign bus.busy        = (state_q == StReplay);
  assign bus.path_valid  = pv_q;
  assign bus.path_dir    = pd_q;
  assign bus.replay_done = rd_q;
endmodule

// File: doc/maze_walk_datapath.md
# maze_walk_datapath

Parametrised position datapath for the maze-walker controller. It holds the walker's X/Y coordinates with a configurable width and applies single-step moves. It rejects moves that would leave the grid at either edge, and it records every accepted move in an on-chip path stack. The stack supports single-step undo (backtracking) and a handshaked replay of the recorded path from start to current position. It sits under the maze controller FSM and replaces the fixed 4-bit two-register datapath.

## Interface
- COORD_W, 4: coordinate width; grid spans 0 .. 2^COORD_W-1 on each axis.
- DEPTH, 16: path-stack entries (power of two, >= 2).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- ld  in  1  load init_x/init_y into position and clear path stack.
- init_x, init_y  in  COORD_W each  start position for ld.
- move  in  1  request one step in direction dir.
- dir  in  2  00: y-1, 01: x+1, 10: x-1, 11: y+1.
- undo  in  1  pop last move and step back.
- replay  in  1  start path replay.
- x, y  out  COORD_W each  current position (registered).
- wrong  out  1  one-cycle pulse: last command rejected.
- at_goal  out  1  combinational: x and y both all-ones.
- depth_cnt  out  $clog2(DEPTH)+1  entries held.
- full, empty  out  1  depth_cnt==DEPTH / depth_cnt==0.
- busy  out  1  high while in REPLAY.
- path_valid  out  1  replay data valid.
- path_dir  out  2  replayed direction.
- path_ready  in  1  consumer accepts path_dir.
- replay_done  out  1  one-cycle pulse after last replay beat.

## Operation
- States: IDLE, REPLAY. Reset to IDLE.
- Reset values: x=0, y=0, depth_cnt=0, wrong=0, path_valid=0, path_dir=0, replay_done=0, busy=0.
- Axis select: dir[1]^dir[0] = 1 selects X, 0 selects Y. dir[0]=1 adds +1, dir[0]=0 adds -1. Arithmetic is modulo 2^COORD_W.
- Edge check: the move is out of bounds when (selected coord + dir[0]) mod 2^COORD_W == 0. This covers decrement at 0 and increment at all-ones.
- IDLE command priority: ld > undo > move > replay. Only one command acts per cycle.
- ld: x<=init_x, y<=init_y, depth_cnt<=0, no wrong.
- move: if out of bounds or full, reject. On reject, position and stack stay unchanged and wrong pulses. Otherwise the selected coordinate is updated and dir is pushed.
- undo: if empty, reject with a wrong pulse. Otherwise pop the top entry d and apply ~d (inverse step). The inverse step is always in bounds and is not edge-checked.
- replay: if empty, replay_done pulses next cycle and the block stays in IDLE. Otherwise enter REPLAY at index 0.
- REPLAY state:
  - path_valid=1 and path_dir=stack[index], oldest entry first.
  - A beat transfers on path_valid & path_ready; index increments.
  - After the beat at index depth_cnt-1: path_valid drops, replay_done pulses, return to IDLE.
  - Position and stack are not modified during REPLAY.
  - move, undo and replay are ignored in REPLAY (no wrong pulse).
  - ld aborts replay: drops path_valid, returns to IDLE, performs the load; no replay_done.
- path_dir must stay stable while path_valid=1 and path_ready=0.
- rst at any time: returns to reset values immediately. Stack contents need not be cleared; depth_cnt=0 makes them invalid.

## Timing
- Registered command effect: command sampled at edge N; x, y, depth_cnt and wrong change after edge N. They are visible in cycle N+1.
- wrong is high for exactly one cycle per rejected command. Back-to-back rejects keep it high on consecutive cycles.
- at_goal, full, empty follow the registered state combinationally (zero extra latency).
- Replay: path_valid rises the cycle after replay is accepted. Maximum throughput is one beat per cycle. replay_done is registered and asserts the cycle after the final transfer, with path_valid low in that cycle.
- Commands held high act every cycle: each cycle is a new request, not edge-detected.

## Test plan
- Reset, then ld with init (0,0); move dir=00 -> wrong=1 for one cycle, (x,y) stays (0,0). Move dir=01 -> x=1, depth_cnt=1.
- COORD_W=4: ld (15,14); move 11 -> y=15, at_goal=1; move 11 again -> wrong pulse, y stays 15.
- DEPTH=4: four legal moves from (5,5) -> full=1; fifth legal move -> wrong pulse, position unchanged, depth_cnt=4.
- Moves 01,01,11 from (2,2) -> (4,3). Three undos -> (4,2), (3,2), (2,2), empty=1. Fourth undo -> wrong pulse.
- Path 01,11,10 recorded; replay with path_ready toggling 1,0,1,1 -> beats 01,11,10 in order, path_dir stable while stalled, replay_done one cycle after the last beat, x/y unchanged.
- During REPLAY assert move and undo -> ignored. Assert ld (7,7) mid-replay -> path_valid drops, no replay_done, position (7,7), depth_cnt=0. Async rst mid-replay -> all outputs at reset values before the next edge.
